// File: rtl/rgals_seq_pkg.sv
// Shared types and defaults for the rGALS reset sequencer and its channel trackers.
// The optional RGALS_SEQ_LATENCY_EN build adds per-channel latency capture.
package rgals_seq_pkg;

    typedef enum logic [2:0] {
        CLK_RST,
        SETTLE,
        DUT_RST,
        RUN,
        DONE,
        TIMEOUT
    } seq_state_e;

    localparam int DEF_NUM_CHANNELS   = 1;
    localparam int DEF_CLK_RST_CYCLES = 8;
    localparam int DEF_SETTLE_CYCLES  = 3;
    localparam int DEF_DUT_RST_CYCLES = 28;
    localparam int DEF_TIMEOUT_CYCLES = 250;
    localparam int DEF_CNT_W          = 16;

    // True when a cnt_w-bit counter can represent every cycle count up to max_cycles.
    function automatic bit cnt_w_fits(input int cnt_w, input int max_cycles);
        if (cnt_w >= 31)
            return 1'b1;
        return (64'(1) << cnt_w) > 64'(max_cycles);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rgals_seq_chan_tracker.sv
// One src/sink channel: sticky completion bit, plus the run-cycle stamp of
// first completion when RGALS_SEQ_LATENCY_EN is defined.
module rgals_seq_chan_tracker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample,
    input  logic             src_done,
    input  logic             sink_done,
`ifdef RGALS_SEQ_LATENCY_EN
    input  logic [CNT_W-1:0] run_cycles,
    output logic [CNT_W-1:0] latency,
`endif
    output logic             done_next,
    output logic             chan_done
);

    logic hit;

    assign hit       = sample & src_done & sink_done;
    assign done_next = chan_done | hit;

    always_ff @(posedge clk) begin
        if (reset || clear)
            chan_done <= 1'b0;
        else
            chan_done <= done_next;
    end

`ifdef RGALS_SEQ_LATENCY_EN
    // Stamp only the first completion; later hits leave the capture alone.
    always_ff @(posedge clk) begin
        if (reset || clear)
            latency <= '0;
        else if (hit && !chan_done)
            latency <= run_cycles;
    end
`endif

endmodule

// File: rtl/rgals_reset_sequencer.sv
// Cycle-exact clk_reset / dut_reset sequencing followed by a done-wait with timeout.
// Define RGALS_SEQ_LATENCY_EN to add the chan_latency capture port.
module rgals_reset_sequencer
    import rgals_seq_pkg::*;
#(
    parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
    parameter int CLK_RST_CYCLES = DEF_CLK_RST_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int DUT_RST_CYCLES = DEF_DUT_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          restart,
    input  logic [NUM_CHANNELS-1:0]       src_done,
    input  logic [NUM_CHANNELS-1:0]       sink_done,
    output logic                          clk_reset,
    output logic                          dut_reset,
    output logic                          running,
    output logic                          finished,
    output logic                          timed_out,
    output logic [NUM_CHANNELS-1:0]       chan_done,
`ifdef RGALS_SEQ_LATENCY_EN
    output logic [NUM_CHANNELS*CNT_W-1:0] chan_latency,
`endif
    output logic [CNT_W-1:0]              run_cycles
);

    localparam logic [CNT_W-1:0] CLK_RST_LAST = CNT_W'(CLK_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DUT_RST_LAST = CNT_W'(DUT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if (!cnt_w_fits(CNT_W, max4(CLK_RST_CYCLES, SETTLE_CYCLES, DUT_RST_CYCLES, TIMEOUT_CYCLES))) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured cycle counts");
    end

    seq_state_e              state, state_nx;
    logic [CNT_W-1:0]        phase_cnt, phase_cnt_nx;
    logic [CNT_W-1:0]        run_cycles_nx;
    logic                    clk_reset_nx, dut_reset_nx;
    logic                    running_nx, finished_nx, timed_out_nx;
    logic                    in_run, restart_ok;
    logic [NUM_CHANNELS-1:0] done_next;

    assign in_run     = (state == RUN);
    assign restart_ok = restart && ((state == DONE) || (state == TIMEOUT));

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        rgals_seq_chan_tracker #(
            .CNT_W (CNT_W)
        ) u_tracker (
            .clk        (clk),
            .reset      (reset),
            .clear      (restart_ok),
            .sample     (in_run),
            .src_done   (src_done[i]),
            .sink_done  (sink_done[i]),
`ifdef RGALS_SEQ_LATENCY_EN
            .run_cycles (run_cycles),
            .latency    (chan_latency[i*CNT_W +: CNT_W]),
`endif
            .done_next  (done_next[i]),
            .chan_done  (chan_done[i])
        );
    end

    always_comb begin
        state_nx      = state;
        phase_cnt_nx  = phase_cnt + 1'b1;
        run_cycles_nx = run_cycles;
        case (state)
            CLK_RST: if (phase_cnt == CLK_RST_LAST) state_nx = SETTLE;
            SETTLE:  if (phase_cnt == SETTLE_LAST)  state_nx = DUT_RST;
            DUT_RST: if (phase_cnt == DUT_RST_LAST) state_nx = RUN;
            RUN: begin
                phase_cnt_nx = phase_cnt;
                if (run_cycles != '1)
                    run_cycles_nx = run_cycles + 1'b1;
                // Completion takes priority over a timeout landing on the same cycle.
                if (&done_next)
                    state_nx = DONE;
                else if (run_cycles == TIMEOUT_LAST)
                    state_nx = TIMEOUT;
            end
            DONE, TIMEOUT: begin
                phase_cnt_nx = phase_cnt;
                if (restart) begin
                    state_nx      = CLK_RST;
                    run_cycles_nx = '0;
                end
            end
            default: state_nx = CLK_RST;
        endcase

        if (state_nx != state)
            phase_cnt_nx = '0;

        clk_reset_nx = (state_nx == CLK_RST);
        dut_reset_nx = (state_nx == CLK_RST) || (state_nx == SETTLE) || (state_nx == DUT_RST);
        running_nx   = (state_nx == RUN);
        finished_nx  = (state_nx == DONE);
        timed_out_nx = (state_nx == TIMEOUT);
    end

    // Outputs are decoded from the next state so they line up with state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLK_RST;
            phase_cnt  <= '0;
            run_cycles <= '0;
            clk_reset  <= 1'b1;
            dut_reset  <= 1'b1;
            running    <= 1'b0;
            finished   <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_nx;
            phase_cnt  <= phase_cnt_nx;
            run_cycles <= run_cycles_nx;
            clk_reset  <= clk_reset_nx;
            dut_reset  <= dut_reset_nx;
            running    <= running_nx;
            finished   <= finished_nx;
            timed_out  <= timed_out_nx;
        end
    end

endmodule

// File: doc/rgals_reset_sequencer.md
Name: rgals_reset_sequencer

Overview:
- Synthesizable successor to the hand-written clock-reset / design-reset / done-wait / timeout sequence in the rGALS block benches.
- Drives the dedicated clock-divider alignment reset and the design reset in a fixed, cycle-exact order.
- Watches a parametrised number of src/sink done channel pairs and reports pass, timeout, and elapsed run cycles.
- Sits at the top of a test harness or SoC test wrapper; a bench or a scan/status register reads its results.

Parameters:
- NUM_CHANNELS, 1, number of src/sink done pairs monitored.
- CLK_RST_CYCLES, 8, cycles clk_reset is held after sequencing starts (min 1).
- SETTLE_CYCLES, 3, cycles between clk_reset deassert and the start of the design reset window (min 1).
- DUT_RST_CYCLES, 28, cycles dut_reset is held after settle (min 1).
- TIMEOUT_CYCLES, 250, run cycles allowed before timeout (min 1).
- CNT_W, 16, width of the phase and run counters; must satisfy 2^CNT_W > max(all cycle parameters).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- restart  in  1  one-cycle pulse; restarts the sequence from CLK_RST; honoured only in DONE or TIMEOUT.
- src_done  in  NUM_CHANNELS  per-channel source-finished level.
- sink_done  in  NUM_CHANNELS  per-channel sink-finished level.
- clk_reset  out  1  clock-divider alignment reset.
- dut_reset  out  1  design reset.
- running  out  1  high in RUN.
- finished  out  1  high in DONE.
- timed_out  out  1  high in TIMEOUT.
- chan_done  out  NUM_CHANNELS  sticky per-channel completion.
- run_cycles  out  CNT_W  cycles spent in RUN; saturates at all-ones.

Behaviour:
- FSM states: CLK_RST, SETTLE, DUT_RST, RUN, DONE, TIMEOUT.
- While reset is high:
  - state=CLK_RST, phase counter=0, run_cycles=0, chan_done=0.
  - clk_reset=1, dut_reset=1, running/finished/timed_out=0.
- CLK_RST:
  - clk_reset=1, dut_reset=1.
  - After CLK_RST_CYCLES cycles counted from the first cycle with reset low, go to SETTLE.
- SETTLE:
  - clk_reset=0, dut_reset=1.
  - After SETTLE_CYCLES cycles, go to DUT_RST.
- DUT_RST:
  - clk_reset=0, dut_reset=1.
  - After DUT_RST_CYCLES cycles, go to RUN.
- Per-phase timing: each phase lasts exactly its parameter count in cycles. The phase counter clears on every state change.
- Outputs are registered, so a state's values appear on the cycle the state is entered.
- RUN:
  - clk_reset=0, dut_reset=0, running=1.
  - chan_done[i] sets when src_done[i] && sink_done[i] is sampled high in RUN, and stays set while in RUN/DONE/TIMEOUT.
  - Done inputs are ignored in every other state.
  - run_cycles increments by one every RUN cycle, saturating.
- Leaving RUN:
  - Next state is DONE when all chan_done bits would be set after this cycle's update.
  - Otherwise next state is TIMEOUT when run_cycles reaches TIMEOUT_CYCLES-1 on this cycle.
  - Simultaneous all-done and timeout: DONE wins.
- DONE / TIMEOUT:
  - clk_reset=0, dut_reset=0.
  - run_cycles and chan_done are frozen.
  - restart=1 goes to CLK_RST; on entry clear chan_done and run_cycles and reassert clk_reset and dut_reset on the next cycle.
- restart in CLK_RST, SETTLE, DUT_RST or RUN is ignored.
- reset mid-operation, in any state: next cycle is the reset values above, with a full sequence restart after release.
- Done inputs high before RUN do not count until sampled in RUN.
- NUM_CHANNELS=1 degenerates to the single-pair harness.

Optional Feature:
- Macro: RGALS_SEQ_LATENCY_EN.
- Defined:
  - Adds output port chan_latency, NUM_CHANNELS*CNT_W wide.
  - Slice i captures run_cycles at the cycle chan_done[i] first sets, then holds.
  - Cleared on reset and restart.
  - Reads 0 for a channel that never completed.
- Undefined:
  - Port absent, no capture registers.
  - All other behaviour identical.

Decomposition:
- Package rgals_seq_pkg holds:
  - the state enum typedef (CLK_RST, SETTLE, DUT_RST, RUN, DONE, TIMEOUT);
  - default cycle-count constants;
  - a localparam function for counter-width checking.
- One natural sub-module, rgals_seq_chan_tracker: per-channel sticky done bit plus optional latency capture, generated NUM_CHANNELS times.

Test Plan:
- Defaults; reset 2 cycles then released; done inputs held low:
  - clk_reset high exactly 8 cycles.
  - clk_reset low and dut_reset high for 3+28 cycles.
  - running asserts at cycle 39 after release.
  - timed_out asserts after 250 RUN cycles with run_cycles=250.
- NUM_CHANNELS=3; channels complete at RUN cycles 10, 40, 25:
  - chan_done bits set accordingly.
  - finished asserts; run_cycles=41.
  - with RGALS_SEQ_LATENCY_EN: latencies 10, 40, 25.
- All channels complete on exactly the final timeout cycle -> finished=1, timed_out=0.
- src_done=sink_done=1 held from reset onward -> no completion before RUN; DONE after the first RUN cycle; run_cycles=1.
- In DONE, pulse restart -> clk_reset and dut_reset reassert next cycle; chan_done=0; run_cycles=0; full sequence repeats. restart pulsed during DUT_RST -> no effect.
- reset asserted mid-RUN at run_cycles=17 -> all outputs return to reset values next cycle; sequence restarts after release.
